pkt_rx_parser: RTL and testbench

Ingress stage of the router. It parses a serial byte stream into packets and checks the CRC-8 of each packet. Header and payload bytes are written into one of NUM_PORTS per-destination synchronous FIFOs. At the end of each packet the block commits the packet (wr_ptr_upd) or discards it (flush) on that FIFO's push/commit/flush interface.

---
 rtl/pkt_rx_parser.sv | 152 +++++++++++++++
 tb/tb_pkt_rx_parser.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_rx_parser.sv
// pkt_rx_parser: router ingress stage. Splits the serial byte stream into
// packets (header, L payload bytes, CRC-8), writes header and payload into
// the per-destination FIFO selected by the header, and at the end of each
// packet either commits it (wr_ptr_upd) or discards it (flush).
module pkt_rx_parser #(
    parameter int NUM_PORTS = 3,
    parameter int CNT_WD    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic [7:0]           fifo_data,
    output logic [NUM_PORTS-1:0] fifo_push,
    output logic [NUM_PORTS-1:0] fifo_wr_ptr_upd,
    output logic [NUM_PORTS-1:0] fifo_flush,
    input  logic [NUM_PORTS-1:0] fifo_full,
    output logic                 busy,
    output logic [CNT_WD-1:0]    drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CRC
    } state_t;

    state_t               state_reg;
    logic [1:0]           dest_reg;
    logic [5:0]           rem_reg;
    logic [7:0]           crc_reg;
    logic                 drop_reg;
    logic                 ovf_reg;
    logic [CNT_WD-1:0]    drop_cnt_reg;
    logic [7:0]           data_reg;
    logic [NUM_PORTS-1:0] pend_reg;
    logic [NUM_PORTS-1:0] upd_reg;
    logic [NUM_PORTS-1:0] flush_reg;

    logic [1:0]           hdr_dest;
    logic [5:0]           hdr_len;
    logic                 hdr_invalid;
    logic [1:0]           dest_sel;
    logic                 data_acc;
    logic                 crc_acc;
    logic                 full_hit;
    logic                 pkt_bad;
    logic [NUM_PORTS-1:0] port_sel;

    // CRC-8, polynomial 0x07, MSB first, one byte folded in per call
    function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    assign hdr_dest    = in_data[7:6];
    assign hdr_len     = in_data[5:0];
    assign hdr_invalid = (int'(hdr_dest) >= NUM_PORTS);

    // Destination of the byte being accepted: the header names it in IDLE,
    // afterwards the captured one applies.
    assign dest_sel = (state_reg == ST_IDLE) ? hdr_dest : dest_reg;
    assign data_acc = in_valid && (state_reg != ST_CRC);
    assign crc_acc  = in_valid && (state_reg == ST_CRC);

    // A push that is being suppressed right now because its FIFO is full.
    // This also covers the last payload push, which lands in the CRC cycle.
    assign full_hit = |(pend_reg & fifo_full);
    assign pkt_bad  = drop_reg || ovf_reg || full_hit || (in_data != crc_reg);

    // One-hot port decode; an out-of-range destination decodes to all zeros,
    // so an invalid packet never touches any FIFO.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port_sel
            assign port_sel[gi] = (dest_sel == 2'(gi));
        end
    endgenerate

    // Packet FSM together with the registered write/commit/flush strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            dest_reg     <= '0;
            rem_reg      <= '0;
            crc_reg      <= '0;
            drop_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
            drop_cnt_reg <= '0;
            data_reg     <= '0;
            pend_reg     <= '0;
            upd_reg      <= '0;
            flush_reg    <= '0;
        end else begin
            pend_reg  <= data_acc ? port_sel : '0;
            upd_reg   <= '0;
            flush_reg <= '0;
            if (data_acc) begin
                data_reg <= in_data;
            end
            if (in_valid && (state_reg == ST_IDLE)) begin
                ovf_reg <= 1'b0;
            end else if (full_hit) begin
                ovf_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        dest_reg  <= hdr_dest;
                        rem_reg   <= hdr_len;
                        crc_reg   <= crc8_upd(8'h00, in_data);
                        drop_reg  <= hdr_invalid;
                        state_reg <= (hdr_len != 6'd0) ? ST_PAYLOAD : ST_CRC;
                    end
                end
                ST_PAYLOAD: begin
                    if (in_valid) begin
                        crc_reg <= crc8_upd(crc_reg, in_data);
                        rem_reg <= rem_reg - 6'd1;
                        if (rem_reg == 6'd1) begin
                            state_reg <= ST_CRC;
                        end
                    end
                end
                ST_CRC: begin
                    if (crc_acc) begin
                        upd_reg   <= pkt_bad ? '0 : port_sel;
                        flush_reg <= pkt_bad ? port_sel : '0;
                        if (pkt_bad && (drop_cnt_reg != '1)) begin
                            drop_cnt_reg <= drop_cnt_reg + 1'b1;
                        end
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // The full flag is sampled in the push cycle itself, hence the late mask
    assign fifo_push       = pend_reg & ~fifo_full;
    assign fifo_data       = data_reg;
    assign fifo_wr_ptr_upd = upd_reg;
    assign fifo_flush      = flush_reg;
    assign busy            = (state_reg != ST_IDLE);
    assign drop_cnt        = drop_cnt_reg;

endmodule

// File: tb/tb_pkt_rx_parser.sv
// tb_pkt_rx_parser: directed packets plus randomized packet traffic, checked
// cycle by cycle against a packet-level reference model.
module tb_pkt_rx_parser;

    localparam int NP  = 3;
    localparam int CW  = 8;
    localparam int SAT = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [7:0]    in_data;
    logic [7:0]    fifo_data;
    logic [NP-1:0] fifo_push;
    logic [NP-1:0] fifo_wr_ptr_upd;
    logic [NP-1:0] fifo_flush;
    logic [NP-1:0] fifo_full;
    logic          busy;
    logic [CW-1:0] drop_cnt;

    pkt_rx_parser #(.NUM_PORTS(NP), .CNT_WD(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .fifo_data       (fifo_data),
        .fifo_push       (fifo_push),
        .fifo_wr_ptr_upd (fifo_wr_ptr_upd),
        .fifo_flush      (fifo_flush),
        .fifo_full       (fifo_full),
        .busy            (busy),
        .drop_cnt        (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    bit            m_in_pkt = 0;
    int            m_dest   = 0;
    int            m_len    = 0;
    logic [7:0]    m_bytes[$];
    bit            m_ovf    = 0;
    int            m_drop   = 0;
    logic [NP-1:0] exp_push  = '0;
    logic [7:0]    exp_data  = '0;
    logic [NP-1:0] exp_upd   = '0;
    logic [NP-1:0] exp_flush = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // CRC-8 poly 0x07 as a bit-serial LFSR over the whole byte list
    function automatic logic [7:0] ref_crc(input logic [7:0] q[$]);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        foreach (q[k]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ q[k][b];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    // packet-level model: consume one accepted byte
    task automatic model_byte(input logic [7:0] d);
        bit good;
        if (!m_in_pkt) begin
            m_bytes  = {d};
            m_dest   = int'(d[7:6]);
            m_len    = int'(d[5:0]);
            m_ovf    = 0;
            m_in_pkt = 1;
            if (m_dest < NP) exp_push[m_dest] = 1'b1;
            exp_data = d;
        end else if (m_bytes.size() < m_len + 1) begin
            m_bytes.push_back(d);
            if (m_dest < NP) exp_push[m_dest] = 1'b1;
            exp_data = d;
        end else begin
            good = (ref_crc(m_bytes) == d) && !m_ovf && (m_dest < NP);
            if (m_dest < NP) begin
                if (good) exp_upd[m_dest] = 1'b1;
                else      exp_flush[m_dest] = 1'b1;
            end
            if (!good && m_drop < SAT) m_drop++;
            m_in_pkt = 0;
        end
    endtask

    // one clock: apply full flags, check outputs caused by last cycle, drive next input
    task automatic step(input logic v, input logic [7:0] d, input logic [NP-1:0] full);
        logic [NP-1:0] want_push;
        @(posedge clk);
        #1;
        fifo_full = full;
        #1;
        want_push = exp_push & ~full;
        check_val("push", 32'(fifo_push), 32'(want_push));
        if (want_push != '0) check_val("data", 32'(fifo_data), 32'(exp_data));
        check_val("upd", 32'(fifo_wr_ptr_upd), 32'(exp_upd));
        check_val("flush", 32'(fifo_flush), 32'(exp_flush));
        check_val("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        check_val("busy", 32'(busy), 32'(m_in_pkt));
        if ((exp_push & full) != '0) m_ovf = 1;
        exp_push  = '0;
        exp_upd   = '0;
        exp_flush = '0;
        in_valid  = v;
        in_data   = d;
        if (v) model_byte(d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, '0);
    endtask

    task automatic send3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int gap);
        step(1'b1, b0, '0); idle(gap);
        step(1'b1, b1, '0); idle(gap);
        step(1'b1, b2, '0); idle(gap);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        fifo_full = '0;
        #1;
        rst_n = 1'b0;
        #1;
        check_val("rst_push", 32'(fifo_push), 32'd0);
        check_val("rst_upd", 32'(fifo_wr_ptr_upd), 32'd0);
        check_val("rst_flush", 32'(fifo_flush), 32'd0);
        check_val("rst_data", 32'(fifo_data), 32'd0);
        check_val("rst_drop", 32'(drop_cnt), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        m_in_pkt  = 0;
        m_ovf     = 0;
        m_drop    = 0;
        exp_push  = '0;
        exp_upd   = '0;
        exp_flush = '0;
    endtask

    function automatic logic [NP-1:0] rand_full(input int pct);
        logic [NP-1:0] f;
        for (int i = 0; i < NP; i++) f[i] = ($urandom_range(0, 99) < pct);
        return f;
    endfunction

    task automatic send_rand_pkt();
        logic [7:0] q[$];
        logic [7:0] crc;
        int         len;
        len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 6);
        q = {{2'($urandom_range(0, 3)), 6'(len)}};
        for (int i = 0; i < len; i++) q.push_back(8'($urandom));
        crc = ref_crc(q);
        if ($urandom_range(0, 3) == 0) crc = crc ^ 8'($urandom_range(1, 255));
        q.push_back(crc);
        foreach (q[k]) begin
            step(1'b1, q[k], rand_full(4));
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                if ($urandom_range(0, 1) == 0) step(1'b0, 8'($urandom), rand_full(4));
            end
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        fifo_full = '0;
        #2;
        do_reset();
        idle(2);

        // good packet, bad CRC, gapped back-to-back packets
        send3(8'h01, 8'hAA, 8'h4A, 0);
        idle(1);
        check_val("t1_drop", 32'(drop_cnt), 32'd0);
        send3(8'h01, 8'hAA, 8'h4B, 0);
        idle(1);
        check_val("t2_drop", 32'(drop_cnt), 32'd1);
        send3(8'h01, 8'hAA, 8'h4A, 3);
        send3(8'h01, 8'hAA, 8'h4A, 0);
        idle(2);

        // invalid destination, then a normal dest-0 packet
        send3(8'hC1, 8'h55, 8'h00, 0);
        send3(8'h01, 8'hAA, 8'h4A, 0);
        idle(1);
        check_val("t4_drop", 32'(drop_cnt), 32'd2);

        // FIFO full during the payload push forces a flush
        step(1'b1, 8'h01, '0);
        step(1'b1, 8'hAA, '0);
        step(1'b1, 8'h4A, 3'b001);
        idle(1);
        check_val("t5_drop", 32'(drop_cnt), 32'd3);

        // randomized traffic
        for (int p = 0; p < 200; p++) send_rand_pkt();
        idle(2);

        // reset in the middle of a packet
        step(1'b1, 8'h3F, '0);
        for (int i = 0; i < 10; i++) step(1'b1, 8'(i * 7 + 3), '0);
        do_reset();
        send3(8'h01, 8'hAA, 8'h4A, 0);
        idle(1);
        check_val("t6_drop", 32'(drop_cnt), 32'd0);

        // saturation of the drop counter
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 8'h00, '0);
            step(1'b1, 8'h01, '0);
        end
        idle(1);
        check_val("sat_drop", 32'(drop_cnt), 32'(SAT));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
